// File: rtl/enigma_pkg.sv
// Shared constants and types for the keypress sequencer in front of the three-rotor chain.
package enigma_pkg;

  localparam int unsigned LETTERS = 26;
  localparam int unsigned CODE_W  = 5;

  localparam logic [CODE_W-1:0] LETTER_A = 5'd0,  LETTER_B = 5'd1,  LETTER_C = 5'd2;
  localparam logic [CODE_W-1:0] LETTER_D = 5'd3,  LETTER_E = 5'd4,  LETTER_F = 5'd5;
  localparam logic [CODE_W-1:0] LETTER_G = 5'd6,  LETTER_H = 5'd7,  LETTER_I = 5'd8;
  localparam logic [CODE_W-1:0] LETTER_J = 5'd9,  LETTER_K = 5'd10, LETTER_L = 5'd11;
  localparam logic [CODE_W-1:0] LETTER_M = 5'd12, LETTER_N = 5'd13, LETTER_O = 5'd14;
  localparam logic [CODE_W-1:0] LETTER_P = 5'd15, LETTER_Q = 5'd16, LETTER_R = 5'd17;
  localparam logic [CODE_W-1:0] LETTER_S = 5'd18, LETTER_T = 5'd19, LETTER_U = 5'd20;
  localparam logic [CODE_W-1:0] LETTER_V = 5'd21, LETTER_W = 5'd22, LETTER_X = 5'd23;
  localparam logic [CODE_W-1:0] LETTER_Y = 5'd24, LETTER_Z = 5'd25;

  localparam logic [CODE_W-1:0] ERR_CODE = 5'd31;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t STEP    = 3'd1;
  localparam state_t SETTLE  = 3'd2;
  localparam state_t DRIVE   = 3'd3;
  localparam state_t CAPTURE = 3'd4;

  // Which rotors receive a step pulse for the current keypress.
  typedef struct packed {
    logic l;
    logic m;
    logic r;
  } step_mask_t;

endpackage

// File: rtl/onehot26_encode.sv
// Combinational one-hot to binary encoder for a 26-letter bus; valid_c means exactly one bit set.
module onehot26_encode
  import enigma_pkg::*;
(
  input  logic [LETTERS-1:0] vec,
  output logic [CODE_W-1:0]  code_c,
  output logic               valid_c
);

  always_comb begin
    code_c  = '0;
    valid_c = ($countones(vec) == 1);
    for (int i = 0; i < int'(LETTERS); i++) begin
      if (vec[i]) code_c = code_c | CODE_W'(i);
    end
  end

endmodule

// File: rtl/rotor_stepper.sv
// Per-keypress sequencer: steps the rotors (with double-step), waits for them to settle,
// drives the letter into the chain and encodes what comes back.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned PROP_CYC   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_valid,
  input  logic [CODE_W-1:0]  key_code,
  output logic               key_ready,
  input  logic               notch_l,
  input  logic               notch_m,
  input  logic               notch_r,
  output logic               rotate_l,
  output logic               rotate_m,
  output logic               rotate_r,
  output logic [LETTERS-1:0] chain_in,
  input  logic [LETTERS-1:0] chain_out,
  output logic               result_valid,
  output logic [CODE_W-1:0]  result_code,
  output logic               err_bad_key,
  output logic               err_chain,
  output logic [15:0]        key_count
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned COUNT_W = 16;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  step_mask_t         mask_q, mask_d;
  logic               accept, bad_key;

  step_mask_t         rotate_d;
  logic               key_ready_d, result_valid_d, err_bad_key_d, err_chain_d, capture;
  logic [LETTERS-1:0] chain_in_d;
  logic [CODE_W-1:0]  result_code_d;
  logic [COUNT_W-1:0] key_count_d;

  logic [CODE_W-1:0]  enc_code_c;
  logic               enc_valid_c;

  // The left rotor has nothing further left to carry into, so its notch never matters.
  logic unused_notch_l;
  assign unused_notch_l = notch_l;

  onehot26_encode u_encode (
    .vec     (chain_out),
    .code_c  (enc_code_c),
    .valid_c (enc_valid_c)
  );

  // State register and registered outputs; reset drops rotate/chain_in without an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      mask_q       <= '0;
      key_ready    <= 1'b1;
      rotate_l     <= 1'b0;
      rotate_m     <= 1'b0;
      rotate_r     <= 1'b0;
      chain_in     <= '0;
      result_valid <= 1'b0;
      result_code  <= '0;
      err_bad_key  <= 1'b0;
      err_chain    <= 1'b0;
      key_count    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      mask_q       <= mask_d;
      key_ready    <= key_ready_d;
      rotate_l     <= rotate_d.l;
      rotate_m     <= rotate_d.m;
      rotate_r     <= rotate_d.r;
      chain_in     <= chain_in_d;
      result_valid <= result_valid_d;
      result_code  <= result_code_d;
      err_bad_key  <= err_bad_key_d;
      err_chain    <= err_chain_d;
      key_count    <= key_count_d;
    end
  end

  // Next state, shared down-counter and per-letter latches (code, step mask).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    mask_d  = mask_q;
    accept  = 1'b0;
    bad_key = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_code < CODE_W'(LETTERS)) begin
            accept  = 1'b1;
            code_d  = key_code;
            // Middle steps on right carry or its own notch (double-step); left follows middle notch.
            mask_d  = '{l: notch_m, m: notch_r | notch_m, r: 1'b1};
            state_d = STEP;
            cnt_d   = CNT_W'(PULSE_W - 1);
          end else begin
            bad_key = 1'b1;
          end
        end
      end
      STEP: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = CNT_W'(PROP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed off the state being entered.
  always_comb begin
    key_ready_d    = (state_d == IDLE);
    rotate_d       = '0;
    chain_in_d     = '0;
    capture        = (state_q == DRIVE) && (state_d == CAPTURE);
    result_valid_d = capture;
    result_code_d  = result_code;
    err_chain_d    = 1'b0;
    err_bad_key_d  = bad_key;
    key_count_d    = key_count + COUNT_W'(accept);
    if (state_d == STEP) rotate_d = mask_d;
    if ((state_d == DRIVE) || (state_d == CAPTURE)) chain_in_d = LETTERS'(1) << code_d;
    if (capture) begin
      result_code_d = enc_valid_c ? enc_code_c : ERR_CODE;
      err_chain_d   = ~enc_valid_c;
    end
  end

endmodule
